// File: rtl/mc_control_fsm.sv
// Moore control FSM for the 16-bit multicycle CPU: decodes the IR opcode into datapath strobes.
// Optional INSTR_CNT_EN macro enables the 16-bit retired-instruction counter.
module mc_control_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  opcode,
  output logic        PCSrc,
  output logic        PC_write,
  output logic        IPR_enable,
  output logic        IR_enable,
  output logic        IM_sel,
  output logic        RegWrite,
  output logic        z,
  output logic        g,
  output logic        ALUSrcA,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [3:0]  state,
  output logic [15:0] retired
);
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_LOAD_IR  = 4'd2,
    S_DECODE   = 4'd3,
    S_EXEC_ALU = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next;

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_IDLE:     w_next = S_FETCH;
      S_FETCH:    w_next = S_LOAD_IR;
      S_LOAD_IR:  w_next = S_DECODE;
      S_DECODE:   w_next = opcode[2] ? (opcode[1] ? S_BRANCH : S_MEM_ADDR) : S_EXEC_ALU;
      S_EXEC_ALU: w_next = S_ALU_WB;
      S_MEM_ADDR: w_next = opcode[0] ? S_MEM_WR : S_MEM_WB;
      default:    w_next = S_FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with r_state.
  always_ff @(posedge clk) begin
    PCSrc      <= 1'b0;
    PC_write   <= 1'b0;
    IPR_enable <= 1'b0;
    IR_enable  <= 1'b0;
    RegWrite   <= 1'b0;
    z          <= 1'b0;
    g          <= 1'b0;
    ALUSrcA    <= 1'b0;
    MemtoReg   <= 1'b0;
    MemWrite   <= 1'b0;
    ALUSrcB    <= 2'b00;
    ALUControl <= 2'b00;
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
      case (w_next)
        S_FETCH: begin
          IPR_enable <= 1'b1;
          PC_write   <= 1'b1;
          ALUSrcB    <= 2'b01;
        end
        S_LOAD_IR:  IR_enable <= 1'b1;
        S_EXEC_ALU: begin
          ALUSrcA    <= 1'b1;
          ALUControl <= opcode[1:0];
        end
        S_ALU_WB:   RegWrite <= 1'b1;
        S_MEM_ADDR: begin
          ALUSrcA <= 1'b1;
          ALUSrcB <= opcode[0] ? 2'b11 : 2'b10;
        end
        S_MEM_WB: begin
          RegWrite <= 1'b1;
          MemtoReg <= 1'b1;
        end
        S_MEM_WR:   MemWrite <= 1'b1;
        S_BRANCH: begin
          ALUSrcA    <= 1'b1;
          ALUControl <= 2'b01;
          PCSrc      <= 1'b1;
          z          <= ~opcode[0];
          g          <= opcode[0];
        end
        default: ;
      endcase
    end
  end

  assign IM_sel = 1'b0;
  assign state  = r_state;

`ifdef INSTR_CNT_EN
  logic [15:0] r_retired;
  logic        w_retire;
  assign w_retire = (r_state == S_ALU_WB) || (r_state == S_MEM_WB) ||
                    (r_state == S_MEM_WR) || (r_state == S_BRANCH);
  always_ff @(posedge clk) begin
    if (rst)           r_retired <= 16'h0000;
    else if (w_retire) r_retired <= r_retired + 16'h0001;
  end
  assign retired = r_retired;
`else
  assign retired = 16'h0000;
`endif
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle control unit for the 16-bit CPU. A Moore state machine that decodes the IR opcode and produces every control strobe consumed by the multicycle datapath, sequencing fetch, IR load, register read, execute, memory and write-back. It sits directly upstream of the datapath: its outputs connect one-to-one to the datapath control inputs, and its only datapath input is the IR opcode field.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  3  Instruction[2:0] from IR
- PCSrc  out  1  0: PC ← ALUResult; 1: PC ← branch target {Instr[15:12],Instr[5:3]}
- PC_write  out  1  unconditional PC enable
- IPR_enable  out  1  prefetch register load
- IR_enable  out  1  IR ← IPR
- IM_sel  out  1  instruction-memory address select; always 0 (PC)
- RegWrite  out  1  register-file write enable
- z  out  1  branch-if-zero qualifier
- g  out  1  branch-if-greater qualifier
- ALUSrcA  out  1  0: PC; 1: regA
- MemtoReg  out  1  0: ALUOut; 1: data memory
- MemWrite  out  1  data-memory write enable
- ALUSrcB  out  2  00 regB, 01 const 1, 10 imm7 Instr[15:9], 11 imm7 {Instr[15:12],Instr[5:3]}
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
- state  out  4  current state encoding (debug)
- retired  out  16  retired-instruction count (see Configuration)

## Operation
- Opcodes:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 LW: rd ← mem[rs1+Instr[15:9]]
  - 101 SW: mem[rs1+{15:12,5:3}] ← rs2
  - 110 BEQ
  - 111 BGT
- Field map: rs1 = [8:6], rs2 = [11:9], rd = [5:3].
- Outputs are a pure function of state. All strobes not listed for a state are 0, and ALUControl/ALUSrcA/ALUSrcB/PCSrc default to 0.
- States (encoding):
  - IDLE(0): all outputs 0 → FETCH.
  - FETCH(1): IPR_enable=1, PC_write=1, ALUSrcB=01, ALUControl=ADD (PC ← PC+1) → LOAD_IR.
  - LOAD_IR(2): IR_enable=1 → DECODE.
  - DECODE(3): no strobes; regA/regB capture the register-file outputs. Next state by opcode:
    - 000–011 → EXEC_ALU
    - 100, 101 → MEM_ADDR
    - 110, 111 → BRANCH
  - EXEC_ALU(4): ALUSrcA=1, ALUSrcB=00, ALUControl=opcode[1:0] → ALU_WB.
  - ALU_WB(5): RegWrite=1, MemtoReg=0 → FETCH.
  - MEM_ADDR(6): ALUSrcA=1, ALUControl=ADD, ALUSrcB=10 for LW and 11 for SW (decoded from opcode[0]). → MEM_WB for LW, MEM_WR for SW.
  - MEM_WB(7): RegWrite=1, MemtoReg=1 → FETCH.
  - MEM_WR(8): MemWrite=1 → FETCH.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUControl=SUB, PCSrc=1, PC_write=0. z=1 for BEQ, g=1 for BGT. The datapath gates the flag. → FETCH.
- Encodings 10–15 are illegal: all outputs 0, next state FETCH.
- An instruction retires on the cycle it leaves ALU_WB, MEM_WB, MEM_WR or BRANCH (taken or not).

## Timing
- Reset: state=IDLE and retired=0 on the edge where rst=1; all outputs 0 while in IDLE. rst asserted mid-instruction aborts it: no RegWrite/MemWrite is issued after that edge, and the aborted instruction does not count.
- First FETCH occurs the cycle after rst deasserts.
- Latency, measured from FETCH to the first cycle of the next FETCH:
  - ALU, LW, SW: 5 cycles
  - BEQ, BGT: 4 cycles
- opcode is sampled only in DECODE and MEM_ADDR. IR is stable from LOAD_IR+1 until the next LOAD_IR.
- A write strobe (RegWrite or MemWrite) lasts exactly 1 cycle per instruction and never appears in two consecutive cycles.
- retired is 16-bit and wraps 0xFFFF → 0x0000.

## Configuration
- INSTR_CNT_EN defined: retired increments by 1 on each retirement, per Operation/Timing.
- Not defined: retired is tied to 16'h0000, and no counter flops are synthesized.
- FSM behaviour is identical in both cases.

## Test plan
- Reset: hold rst 3 cycles → state=0 and all strobes 0. Release → state sequence 1,2,3.
- ADD (opcode 000) → states 1,2,3,4,5,1. ALU_WB has RegWrite=1, MemtoReg=0. EXEC_ALU has ALUControl=00, ALUSrcA=1, ALUSrcB=00. OR (011) → ALUControl=11.
- LW (100) → MEM_ADDR with ALUSrcB=10, then MEM_WB with RegWrite=1, MemtoReg=1. SW (101) → MEM_ADDR with ALUSrcB=11, then MEM_WR with MemWrite=1 and RegWrite=0.
- BEQ (110) → BRANCH: z=1, g=0, PCSrc=1, ALUControl=01, PC_write=0. Next state FETCH (4-cycle instruction). BGT (111) → g=1, z=0.
- Assert rst during MEM_ADDR of a SW → next cycle state=0, and MemWrite is never asserted.
- With INSTR_CNT_EN: 10 mixed instructions → retired=10. Preload retired=0xFFFF via a long run → wraps to 0. Without the macro, retired stays 0.
